dispatch_queue: RTL

Circular instruction buffer placed directly after the 4-lane packing stage (queue feeder) in the front end. It accepts up to four packed 57-bit operations per cycle and holds them in program order. It issues up to two operations per cycle to the reservation-station dispatch logic through an in-order valid/ready handshake. It exerts backpressure upstream and supports a single-cycle flush on mispredict.

---
 rtl/oop_pkg.sv | 7 +
 rtl/dispatch_queue_mem.sv | 23 ++
 rtl/dispatch_queue.sv | 77 +++++++
 3 files changed

// File: rtl/oop_pkg.sv
// oop_pkg: shared operation width, operation type and front-end lane counts
package oop_pkg;
   localparam int OP_W = 57;
   typedef logic [OP_W-1:0] op_t;
   localparam int DISPATCH_LANES = 2;
   localparam int FEED_LANES = 4;
endpackage

// File: rtl/dispatch_queue_mem.sv
// dispatch_queue_mem: DEPTH x OP_W storage, four consecutive write ports from one base, reads at base and base+1, all wrapping
module dispatch_queue_mem
   import oop_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic [AW-1:0]         wrBase,
   input  logic [FEED_LANES-1:0] wrEn,
   input  op_t [FEED_LANES-1:0]  wrData,
   input  logic [AW-1:0]         rdBase,
   output op_t                   rdA,
   output op_t                   rdB
);
   op_t mem [DEPTH];
   // Lane i lands at wrBase+i; address arithmetic wraps naturally at AW bits
   always_ff @(posedge clk)
      for (int i = 0; i < FEED_LANES; i++)
         if (wrEn[i]) mem[wrBase + AW'(i)] <= wrData[i];
   assign rdA = mem[rdBase];
   assign rdB = mem[rdBase + AW'(1)];
endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order 4-in/2-out circular instruction buffer with flush; DISPATCH_QUEUE_STATS_EN adds a stall_cycles counter
module dispatch_queue
   import oop_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  op_t           in_op_a,
   input  op_t           in_op_b,
   input  op_t           in_op_c,
   input  op_t           in_op_d,
   input  logic          in_valid_a,
   input  logic          in_valid_b,
   input  logic          in_valid_c,
   input  logic          in_valid_d,
   output logic          in_ready,
   input  logic          flush,
   output op_t           out_op_a,
   output op_t           out_op_b,
   output logic          out_valid_a,
   output logic          out_valid_b,
   input  logic          out_ready_a,
   input  logic          out_ready_b,
   output logic [CW-1:0] count
`ifdef DISPATCH_QUEUE_STATS_EN
   ,
   output logic [31:0]   stall_cycles
`endif
);
   logic [AW-1:0] head, tail;
   logic enq, deqA, deqB;
   logic [2:0] nEnq;
   logic [1:0] nDeq;
   assign in_ready = count <= CW'(DEPTH - FEED_LANES);
   assign out_valid_a = count != '0;
   assign out_valid_b = count > CW'(1);
   assign enq = in_ready && in_valid_a;
   assign nEnq = enq ? 3'(in_valid_a) + 3'(in_valid_b) + 3'(in_valid_c) + 3'(in_valid_d) : 3'd0;
   assign deqA = out_valid_a && out_ready_a;
   assign deqB = deqA && out_valid_b && out_ready_b;
   assign nDeq = 2'(deqA) + 2'(deqB);
   // Pointers and occupancy; flush empties the queue and wins over any enqueue/dequeue
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(nDeq);
         tail  <= tail + AW'(nEnq);
         count <= count + CW'(nEnq) - CW'(nDeq);
      end
   dispatch_queue_mem #(.DEPTH(DEPTH)) mem (
      .clk    (clk),
      .wrBase (tail),
      .wrEn   ((enq && !flush) ? {in_valid_d, in_valid_c, in_valid_b, in_valid_a} : 4'b0),
      .wrData ({in_op_d, in_op_c, in_op_b, in_op_a}),
      .rdBase (head),
      .rdA    (out_op_a),
      .rdB    (out_op_b)
   );
`ifdef DISPATCH_QUEUE_STATS_EN
   // Count cycles an offered group is refused for lack of space, saturating
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stall_cycles <= '0;
      else if (in_valid_a && !in_ready && !flush && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
`endif
   packedValids: assert property (@(posedge clk) disable iff (!rst_n)
      (!in_valid_b || in_valid_a) && (!in_valid_c || in_valid_b) && (!in_valid_d || in_valid_c));
endmodule
